// File: rtl/switch_pkg.sv
// Shared types and packet-size constants for the 4-port packet switch output path.
package switch_pkg;

    localparam int PKT_HDR_BYTES = 3;
    localparam int MAX_PAYLOAD   = 255;
    localparam int MAX_PKT_BYTES = 259;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_SEND = 2'd1,
        RD_GAP  = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic       eop;
        logic [7:0] byte_v;
    } port_word_t;

endpackage

// File: rtl/port_fifo_mem.sv
// Packet byte storage: DEPTH x {eop, byte}, synchronous write, asynchronous read.
module port_fifo_mem
    import switch_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       wr_en,
    input  logic [AW-1:0] wr_addr,
    input  port_word_t wr_word,
    input  logic [AW-1:0] rd_addr,
    output port_word_t rd_word
);

    port_word_t mem_q [DEPTH];

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem_q[rd_addr];

endmodule

// File: rtl/switch_output_port.sv
// Store-and-forward output port: buffers whole packets, then streams them on ready/read.
// Optional parity checking is built when SWITCH_PORT_PARITY_CHECK_EN is defined.
module switch_output_port
    import switch_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       wr_eop,
    output logic       space_ok,
    output logic       overflow,
    output logic       parity_err,
    output logic       ready,
    input  logic       read,
    output logic [7:0] data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT      = CW'(DEPTH);
    localparam logic [CW-1:0] SPACE_MAX_CNT = CW'(DEPTH - MAX_PKT_BYTES);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    rd_state_e     state_q;
    logic [7:0]    data_q;
    logic          overflow_q;

    logic       full, push, push_eop, pop, pop_eop;
    port_word_t rd_word;

    assign full     = (count_q == FULL_CNT);
    assign push     = wr_en && !full;
    assign push_eop = push && wr_eop;

    // Combinational from state and pkt_cnt only; read never feeds back into ready.
    assign ready    = (state_q == RD_SEND) || ((state_q == RD_IDLE) && (pkt_cnt_q != '0));
    assign pop      = read && ready;
    assign pop_eop  = pop && rd_word.eop;

    assign space_ok = (count_q <= SPACE_MAX_CNT);
    assign overflow = overflow_q;
    assign data     = data_q;

    port_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_word ('{eop: wr_eop, byte_v: wr_data}),
        .rd_addr (rd_ptr_q),
        .rd_word (rd_word)
    );

    // NOTE: combinational next-state uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        pkt_cnt_d = pkt_cnt_q;
        if (push_eop && !pop_eop) begin
            pkt_cnt_d = pkt_cnt_q + CW'(1);
        end else if (!push_eop && pop_eop) begin
            pkt_cnt_d = pkt_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RD_IDLE;
            rd_ptr_q <= '0;
            data_q   <= 8'h00;
        end else begin
            unique case (state_q)
                RD_IDLE, RD_SEND: begin
                    if (pop) begin
                        data_q   <= rd_word.byte_v;
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                        state_q  <= rd_word.eop ? RD_GAP : RD_SEND;
                    end
                end
                RD_GAP:  state_q <= RD_IDLE;
                default: state_q <= RD_IDLE;
            endcase
        end
    end

`ifdef SWITCH_PORT_PARITY_CHECK_EN
    logic [7:0] par_acc_q;
    logic [7:0] par_next;
    logic       par_err_q;

    assign par_next = par_acc_q ^ wr_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_acc_q <= 8'h00;
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= push_eop && (par_next != 8'h00);
            if (push) begin
                par_acc_q <= wr_eop ? 8'h00 : par_next;
            end
        end
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_output_port.sv
// Scoreboard bench for switch_output_port: written bytes are queued, popped and compared as they are read.
`timescale 1ns/1ps
module tb_switch_output_port;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_eop;
    logic       space_ok;
    logic       overflow;
    logic       parity_err;
    logic       ready;
    logic       read;
    logic [7:0] data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    localparam int BUDGET = 2000;

`ifdef SWITCH_PORT_PARITY_CHECK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    switch_output_port #(.DEPTH(512)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_eop     (wr_eop),
        .space_ok   (space_ok),
        .overflow   (overflow),
        .parity_err (parity_err),
        .ready      (ready),
        .read       (read),
        .data       (data)
    );

    always #5 clock = ~clock;

    task automatic write_byte(input logic [7:0] b, input logic eop, input bit stored);
        wr_en   = 1'b1;
        wr_data = b;
        wr_eop  = eop;
        if (stored) exp_q.push_back(b);
        @(posedge clock); #1;
        wr_en  = 1'b0;
        wr_eop = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                               input logic [7:0] base, input bit corrupt);
        logic [7:0] par;
        logic [7:0] b;
        par = da ^ sa ^ len;
        write_byte(da, 1'b0, 1'b1);
        write_byte(sa, 1'b0, 1'b1);
        write_byte(len, 1'b0, 1'b1);
        for (int i = 0; i < int'(len); i++) begin
            b = base + 8'(i);
            par ^= b;
            write_byte(b, 1'b0, 1'b1);
        end
        write_byte(corrupt ? (par ^ 8'h01) : par, 1'b1, 1'b1);
    endtask

    // One clock step; reports whether a read was accepted at that edge.
    task automatic read_cycle(output bit popped);
        popped = read && ready;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        read    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (ready !== 1'b0)      begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (data !== 8'h00)      begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++; if (space_ok !== 1'b1)   begin n_bad++; $display("FAIL reset_space_ok: got %b want 1", space_ok); end
        n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_read_ready: got %b want 0", ready); end
        n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_read_data: got %h want 00", data); end
        read = 1'b0;
    endtask

    task automatic test_single_packet;
        bit popped;
        int cycles;
        int low;
        logic [7:0] e;
        logic [7:0] last;
        send_packet(8'h02, 8'h05, 8'h04, 8'hA0, 1'b0);
        n_cmp++; if (ready !== 1'b1)      begin n_bad++; $display("FAIL single_ready_rise: got %b want 1", ready); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL single_parity_ok: got %b want 0", parity_err); end
        read = 1'b1;
        cycles = 0; low = 0; last = 8'h00;
        while (exp_q.size() != 0 && cycles < BUDGET) begin
            if (!ready) low++;
            read_cycle(popped);
            cycles++;
            if (popped) begin
                e = exp_q.pop_front();
                last = e;
                n_cmp++; if (data !== e) begin n_bad++; $display("FAIL single_data: got %h want %h", data, e); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL single_timeout: %0d bytes left want 0", exp_q.size()); exp_q.delete(); end
        n_cmp++; if (low != 0)       begin n_bad++; $display("FAIL single_contiguous: got %0d low cycles want 0", low); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL single_gap: got %b want 0", ready); end
        repeat (2) begin
            read_cycle(popped);
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL single_after_gap_ready: got %b want 0", ready); end
            n_cmp++; if (data !== last)  begin n_bad++; $display("FAIL single_data_hold: got %h want %h", data, last); end
        end
        read = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit popped;
        int cycles;
        int low;
        int n_pop;
        int first_gap;
        logic [7:0] e;
        send_packet(8'h10, 8'h11, 8'h00, 8'h00, 1'b0);
        send_packet(8'h20, 8'h21, 8'hFF, 8'h00, 1'b0);
        read = 1'b1;
        cycles = 0; low = 0; n_pop = 0; first_gap = -1;
        while (exp_q.size() != 0 && cycles < BUDGET) begin
            if (!ready && n_pop > 0) begin
                low++;
                if (first_gap < 0) first_gap = n_pop;
            end
            read_cycle(popped);
            cycles++;
            if (popped) begin
                e = exp_q.pop_front();
                n_pop++;
                n_cmp++; if (data !== e) begin n_bad++; $display("FAIL b2b_data: byte %0d got %h want %h", n_pop, data, e); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_timeout: %0d bytes left want 0", exp_q.size()); exp_q.delete(); end
        n_cmp++; if (n_pop != 263)     begin n_bad++; $display("FAIL b2b_total: got %0d want 263", n_pop); end
        n_cmp++; if (first_gap != 4)   begin n_bad++; $display("FAIL b2b_first_len: got %0d want 4", first_gap); end
        n_cmp++; if (low != 1)         begin n_bad++; $display("FAIL b2b_gap_cycles: got %0d want 1", low); end
        repeat (2) begin
            read_cycle(popped);
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_drained_ready: got %b want 0", ready); end
        end
        read = 1'b0;
    endtask

    task automatic test_pause;
        bit popped;
        int cycles;
        logic [7:0] e;
        send_packet(8'h02, 8'h05, 8'h04, 8'hA0, 1'b0);
        read = 1'b1;
        repeat (2) begin
            read_cycle(popped);
            if (popped) begin
                e = exp_q.pop_front();
                n_cmp++; if (data !== e) begin n_bad++; $display("FAIL pause_head: got %h want %h", data, e); end
            end
        end
        read = 1'b0;
        repeat (3) begin
            read_cycle(popped);
            n_cmp++; if (data !== 8'h05) begin n_bad++; $display("FAIL pause_hold: got %h want 05", data); end
            n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL pause_ready: got %b want 1", ready); end
        end
        read = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < BUDGET) begin
            read_cycle(popped);
            cycles++;
            if (popped) begin
                e = exp_q.pop_front();
                n_cmp++; if (data !== e) begin n_bad++; $display("FAIL pause_resume: got %h want %h", data, e); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL pause_timeout: %0d bytes left want 0", exp_q.size()); exp_q.delete(); end
        read_cycle(popped);
        read = 1'b0;
        read_cycle(popped);
    endtask

    task automatic test_parity;
        bit popped;
        int cycles;
        logic [7:0] e;
        send_packet(8'h02, 8'h05, 8'h04, 8'hA0, 1'b1);
        n_cmp++; if (parity_err !== PAR_EN) begin n_bad++; $display("FAIL parity_pulse: got %b want %b", parity_err, PAR_EN); end
        read_cycle(popped);
        n_cmp++; if (parity_err !== 1'b0)   begin n_bad++; $display("FAIL parity_one_cycle: got %b want 0", parity_err); end
        read = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < BUDGET) begin
            read_cycle(popped);
            cycles++;
            if (popped) begin
                e = exp_q.pop_front();
                n_cmp++; if (data !== e) begin n_bad++; $display("FAIL parity_forward: got %h want %h", data, e); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL parity_timeout: %0d bytes left want 0", exp_q.size()); exp_q.delete(); end
        read_cycle(popped);
        read = 1'b0;
        read_cycle(popped);
    endtask

    task automatic test_overflow;
        bit popped;
        int cycles;
        logic [7:0] e;
        logic [7:0] par;
        logic [7:0] bytes[$];
        logic       eops[$];
        for (int p = 0; p < 2; p++) begin
            bytes.push_back(8'h40 + 8'(p)); eops.push_back(1'b0);
            bytes.push_back(8'h50 + 8'(p)); eops.push_back(1'b0);
            bytes.push_back(8'd252);        eops.push_back(1'b0);
            par = (8'h40 + 8'(p)) ^ (8'h50 + 8'(p)) ^ 8'd252;
            for (int i = 0; i < 252; i++) begin
                bytes.push_back(8'(i * 3 + p)); eops.push_back(1'b0);
                par ^= 8'(i * 3 + p);
            end
            bytes.push_back(par); eops.push_back(1'b1);
        end
        for (int i = 0; i < 512; i++) begin
            write_byte(bytes[i], eops[i], 1'b1);
            if (i == 252) begin
                n_cmp++; if (space_ok !== 1'b1) begin n_bad++; $display("FAIL ovf_space_253: got %b want 1", space_ok); end
            end
            if (i == 253) begin
                n_cmp++; if (space_ok !== 1'b0) begin n_bad++; $display("FAIL ovf_space_254: got %b want 0", space_ok); end
            end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %b want 0", overflow); end
        write_byte(8'hEE, 1'b1, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        read = 1'b1;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < BUDGET) begin
            read_cycle(popped);
            cycles++;
            if (popped) begin
                e = exp_q.pop_front();
                n_cmp++; if (data !== e) begin n_bad++; $display("FAIL ovf_data: got %h want %h", data, e); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ovf_timeout: %0d bytes left want 0", exp_q.size()); exp_q.delete(); end
        repeat (3) begin
            read_cycle(popped);
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL ovf_dropped_eop: ready got %b want 0", ready); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        n_cmp++; if (space_ok !== 1'b1) begin n_bad++; $display("FAIL ovf_space_back: got %b want 1", space_ok); end
        read = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        wr_eop  = 1'b0;
        read    = 1'b0;
        #1;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_pause();
        test_parity();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
